uart_rx_sipo: RTL and testbench

Receive-side serial-to-parallel stage of the UART. It oversamples the asynchronous `rx_in` line on the 16x baud tick, detects and qualifies the start bit, and samples each bit at mid-period. It assembles the complete 11-bit frame (start, 8 data LSB-first, parity, stop) and hands it to the frame-field decoder as `data_parll`, with a one-cycle `frame_valid` strobe. It does not check parity or stop bits; it delivers raw frame bits only.

---
 rtl/uart_rx_sipo_pkg.sv | 37 +++
 rtl/uart_rx_sipo_if.sv | 16 +
 rtl/uart_rx_sipo_sync_2ff.sv | 30 +++
 rtl/uart_rx_sipo.sv | 139 +++++++++++++
 tb/tb_uart_rx_sipo.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_sipo_pkg.sv
// rtl/uart_rx_sipo_pkg.sv - shared UART receive types and frame field positions
// Purpose : state encoding for the receive FSM and the bit positions of each
//           field inside an assembled frame, shared with the frame decoder.
// Ports   : none (package).
package uart_rx_sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

  localparam int START_IDX  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;

  // Field extraction helpers for consumers of data_parll.
  function automatic logic [DATA_MSB-DATA_LSB:0] frame_data(input logic [STOP_IDX:0] f);
    return f[DATA_MSB:DATA_LSB];
  endfunction

  function automatic logic frame_parity(input logic [STOP_IDX:0] f);
    return f[PARITY_IDX];
  endfunction

  function automatic logic frame_stop(input logic [STOP_IDX:0] f);
    return f[STOP_IDX];
  endfunction

  function automatic logic frame_start(input logic [STOP_IDX:0] f);
    return f[START_IDX];
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// rtl/uart_rx_sipo_if.sv - frame output bus from the receiver to the decoder
// Purpose : groups the assembled-frame outputs of the receiver.
// Ports   : data_parll  - last captured frame (bit 0 start ... top bit stop)
//           frame_valid - one-cycle strobe when data_parll is updated
//           rx_busy     - receiver is inside a frame
//           master      - receiver side (drives), slave - decoder side (reads)
interface uart_rx_sipo_if #(
  parameter int FRAME_BITS = 11
);
  logic [FRAME_BITS-1:0] data_parll;
  logic                  frame_valid;
  logic                  rx_busy;

  modport master (output data_parll, output frame_valid, output rx_busy);
  modport slave  (input  data_parll, input  frame_valid, input  rx_busy);
endinterface

// File: rtl/uart_rx_sipo_sync_2ff.sv
// rtl/uart_rx_sipo_sync_2ff.sv - two-flop synchronizer, resets to 1
// Purpose : brings an asynchronous level into the clk domain. Resets high so
//           an idle-high serial line does not look like a start bit.
// Ports   : clk, rst_n (async active-low), d_in (async), q_out (synchronized)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;
endmodule

// File: rtl/uart_rx_sipo.sv
// rtl/uart_rx_sipo.sv - UART receive oversampler and serial-to-parallel stage
// Purpose : qualifies the start bit, samples each bit at mid-period on the
//           oversampled baud tick and delivers the raw frame (no parity or
//           stop checking).
// Ports   : PCLK, PRESETn (async active-low)
//           rx_in      - asynchronous serial line, idle high
//           baud_tick  - one-cycle pulse at OVERSAMPLE x baud
//           rx_enable  - low aborts any frame and holds IDLE
//           rx_out     - frame output bus (data_parll, frame_valid, rx_busy)
module uart_rx_sipo
  import uart_rx_sipo_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 11
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            rx_in,
  input  logic            baud_tick,
  input  logic            rx_enable,
  uart_rx_sipo_if.master  rx_out
);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam logic [TICK_W-1:0] HALF_M1   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_M1   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(FRAME_BITS);

  logic rx_s;

  rx_state_e             state_d, state_q;
  logic [TICK_W-1:0]     tick_cnt_d, tick_cnt_q;
  logic [BIT_W-1:0]      bit_cnt_d, bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_d, shift_q;
  logic [FRAME_BITS-1:0] data_d, data_q;
  logic                  valid_d, valid_q;
  logic [BIT_W-1:0]      bit_cnt_inc;

  sync_2ff u_sync (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .d_in  (rx_in),
    .q_out (rx_s)
  );

  assign bit_cnt_inc = bit_cnt_q + BIT_W'(1);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;

    if (!rx_enable) begin
      // Abort wins over everything, including a frame sitting in DONE.
      state_d    = IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (baud_tick && !rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt_q == HALF_M1) begin
              tick_cnt_d = '0;
              if (!rx_s) begin
                // Start bit confirmed at its centre; it becomes frame bit 0
                // after the remaining shifts.
                shift_d   = {rx_s, shift_q[FRAME_BITS-1:1]};
                bit_cnt_d = BIT_W'(1);
                state_d   = DATA;
              end else begin
                state_d = IDLE;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tick_cnt_q == FULL_M1) begin
              tick_cnt_d = '0;
              shift_d    = {rx_s, shift_q[FRAME_BITS-1:1]};
              bit_cnt_d  = bit_cnt_inc;
              if (bit_cnt_inc == BITS_LAST) begin
                state_d = DONE;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
          end
        end
        DONE: begin
          // Output register and strobe load together on the edge leaving
          // DONE, so data_parll only ever moves while frame_valid is high.
          data_d    = shift_q;
          valid_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      data_q     <= '1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign rx_out.data_parll  = data_q;
  assign rx_out.frame_valid = valid_q;
  assign rx_out.rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb/tb_uart_rx_sipo.sv - scoreboard bench for uart_rx_sipo
module tb_uart_rx_sipo;
  logic clk = 1'b0;
  logic rst_n;
  logic rx_in;
  logic baud_tick;
  logic rx_enable;

  uart_rx_sipo_if #(.FRAME_BITS(11)) rx_if ();

  uart_rx_sipo #(.OVERSAMPLE(16), .FRAME_BITS(11)) dut (
    .PCLK      (clk),
    .PRESETn   (rst_n),
    .rx_in     (rx_in),
    .baud_tick (baud_tick),
    .rx_enable (rx_enable),
    .rx_out    (rx_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [10:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Rx_in falls at edge k (+1ns): 2 sync flops, detection on tick edge k+4,
  // stop sample 168 ticks (672 clocks) later at k+676, DONE, strobe at k+677.
  localparam int VALID_LAT = 677;

  always @(posedge clk) cyc <= cyc + 1;

  // baud_tick: one cycle in four, changed 1ns after the rising edge.
  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected frame, both in
  // content and in the cycle it appears.
  always @(negedge clk) begin
    if (rx_if.frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_valid: got pulse with data_parll=%0h, expected none", rx_if.data_parll);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_data", 32'(rx_if.data_parll), 32'(e.data));
        check("frame_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Returns 1ns after the next rising edge that carried a baud tick.
  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = f[i];
      repeat (16) wait_tick();
    end
  endtask

  // Caller must be sitting 1ns after a tick edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic [10:0] exp_data);
    exp_t e;
    e.data = exp_data;
    e.cyc  = cyc + VALID_LAT;
    exp_q.push_back(e);
    send_bits({s, p, d, 1'b0}, 11);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    rx_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_parll", 32'(rx_if.data_parll), 32'h7FF);
    check("reset_frame_valid", 32'(rx_if.frame_valid), 32'h0);
    check("reset_rx_busy", 32'(rx_if.rx_busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) wait_tick();

    // False start: low for 5 ticks only.
    rx_in = 1'b0;
    repeat (3) wait_tick();
    check("false_start_busy", 32'(rx_if.rx_busy), 32'h1);
    repeat (2) wait_tick();
    rx_in = 1'b1;
    repeat (20) wait_tick();
    check("false_start_idle", 32'(rx_if.rx_busy), 32'h0);
    check("false_start_data", 32'(rx_if.data_parll), 32'h7FF);

    send_frame(8'h5A, 1'b0, 1'b1, 11'h4B4);
    repeat (16) wait_tick();
    check("idle_after_5a", 32'(rx_if.rx_busy), 32'h0);

    // Framing error delivered raw; line returns high afterwards.
    send_frame(8'hFF, 1'b0, 1'b0, 11'h1FE);
    rx_in = 1'b1;
    repeat (32) wait_tick();

    // Back to back, no idle gap.
    send_frame(8'h01, 1'b1, 1'b1, 11'h602);
    send_frame(8'h80, 1'b1, 1'b1, 11'h700);
    repeat (16) wait_tick();

    // Enable dropped half-way through data bit 4.
    send_bits({1'b1, 1'b0, 8'hC3, 1'b0}, 5);
    repeat (8) wait_tick();
    check("abort_busy_before", 32'(rx_if.rx_busy), 32'h1);
    rx_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_after", 32'(rx_if.rx_busy), 32'h0);
    rx_in = 1'b1;
    repeat (24) wait_tick();
    check("abort_data_hold", 32'(rx_if.data_parll), 32'h700);
    rx_enable = 1'b1;
    repeat (4) wait_tick();
    send_frame(8'hA5, 1'b0, 1'b1, 11'h54A);
    repeat (16) wait_tick();

    // Asynchronous reset during data bit 6, between clock edges.
    send_bits({1'b1, 1'b1, 8'h99, 1'b0}, 7);
    repeat (4) wait_tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_data_parll", 32'(rx_if.data_parll), 32'h7FF);
    check("midreset_frame_valid", 32'(rx_if.frame_valid), 32'h0);
    check("midreset_rx_busy", 32'(rx_if.rx_busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_in = 1'b1;
    repeat (8) wait_tick();
    send_frame(8'h3C, 1'b1, 1'b1, 11'h678);
    repeat (16) wait_tick();

    repeat (50) @(posedge clk);
    check("pending_frames", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
